// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: FSM states, parity encodings
// and the bit-period reload helper (also usable by the receive path).
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_EVEN = 2'd1;
  localparam logic [1:0] PARITY_ODD  = 2'd2;

  localparam int BIT_MULT    = 8;
  localparam int TIMER_WIDTH = 19;

  // Reload value for one bit period; a prescale of 0 behaves like 1.
  function automatic logic [TIMER_WIDTH-1:0] bit_reload(input logic [15:0] prescale);
    logic [TIMER_WIDTH-1:0] p;
    p = (prescale == 16'd0) ? TIMER_WIDTH'(1) : TIMER_WIDTH'(prescale);
    return p * TIMER_WIDTH'(BIT_MULT) - TIMER_WIDTH'(1);
  endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Loadable down-counter that flags expiry when it reads zero at an edge.
// Shared between the transmit and receive paths.
module uart_baud_timer
  import uart_tx_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/uart_tx.sv
// AXI4-Stream to serial UART transmitter: start bit, LSB-first data,
// optional parity, one or two stop bits, bit period of prescale*8 cycles.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] input_axi_tdata,
  input  logic                  input_axi_tvalid,
  output logic                  input_axi_tready,
  output logic                  txd,
  output logic                  busy,
  input  logic [15:0]           prescale,
  input  logic [1:0]            parity_mode,
  input  logic                  stop_bits
);

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH);

  tx_state_t               state, state_n;
  logic                    txd_q, txd_n;
  logic                    tready_q, tready_n;
  logic [DATA_WIDTH-1:0]   shift_q, shift_n;
  logic [DATA_WIDTH-1:0]   data_q, data_n;
  logic [3:0]              bit_cnt, bit_cnt_n;
  logic                    stop_left, stop_left_n;
  logic [TIMER_WIDTH-1:0]  cfg_reload, cfg_reload_n;
  logic [1:0]              cfg_parity, cfg_parity_n;
  logic                    cfg_stop, cfg_stop_n;
  logic                    timer_load;
  logic [TIMER_WIDTH-1:0]  timer_value;
  logic                    timer_expire;
  logic                    parity_en;

  uart_baud_timer #(
    .WIDTH(TIMER_WIDTH)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (timer_load),
    .load_value(timer_value),
    .expire    (timer_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      txd_q      <= 1'b1;
      tready_q   <= 1'b0;
      shift_q    <= '0;
      data_q     <= '0;
      bit_cnt    <= '0;
      stop_left  <= 1'b0;
      cfg_reload <= '0;
      cfg_parity <= PARITY_NONE;
      cfg_stop   <= 1'b0;
    end else begin
      state      <= state_n;
      txd_q      <= txd_n;
      tready_q   <= tready_n;
      shift_q    <= shift_n;
      data_q     <= data_n;
      bit_cnt    <= bit_cnt_n;
      stop_left  <= stop_left_n;
      cfg_reload <= cfg_reload_n;
      cfg_parity <= cfg_parity_n;
      cfg_stop   <= cfg_stop_n;
    end
  end

  assign parity_en = (cfg_parity == PARITY_EVEN) || (cfg_parity == PARITY_ODD);

  // Frame configuration is frozen at the handshake; every later reload uses cfg_reload.
  always_comb begin
    state_n      = state;
    txd_n        = txd_q;
    tready_n     = tready_q;
    shift_n      = shift_q;
    data_n       = data_q;
    bit_cnt_n    = bit_cnt;
    stop_left_n  = stop_left;
    cfg_reload_n = cfg_reload;
    cfg_parity_n = cfg_parity;
    cfg_stop_n   = cfg_stop;
    timer_load   = 1'b0;
    timer_value  = cfg_reload;

    case (state)
      IDLE: begin
        txd_n    = 1'b1;
        tready_n = 1'b1;
        if (input_axi_tvalid && tready_q) begin
          shift_n      = input_axi_tdata;
          data_n       = input_axi_tdata;
          cfg_reload_n = bit_reload(prescale);
          cfg_parity_n = parity_mode;
          cfg_stop_n   = stop_bits;
          timer_load   = 1'b1;
          timer_value  = bit_reload(prescale);
          txd_n        = 1'b0;
          tready_n     = 1'b0;
          state_n      = START;
        end
      end
      START: begin
        if (timer_expire) begin
          timer_load = 1'b1;
          txd_n      = shift_q[0];
          shift_n    = shift_q >> 1;
          bit_cnt_n  = 4'd1;
          state_n    = DATA;
        end
      end
      DATA: begin
        if (timer_expire) begin
          timer_load = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            if (parity_en) begin
              txd_n   = (^data_q) ^ (cfg_parity == PARITY_ODD);
              state_n = PARITY;
            end else begin
              txd_n       = 1'b1;
              stop_left_n = cfg_stop;
              state_n     = STOP;
            end
          end else begin
            txd_n     = shift_q[0];
            shift_n   = shift_q >> 1;
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
      end
      PARITY: begin
        if (timer_expire) begin
          timer_load  = 1'b1;
          txd_n       = 1'b1;
          stop_left_n = cfg_stop;
          state_n     = STOP;
        end
      end
      STOP: begin
        if (timer_expire) begin
          if (stop_left) begin
            timer_load  = 1'b1;
            stop_left_n = 1'b0;
          end else begin
            tready_n = 1'b1;
            state_n  = IDLE;
          end
        end
      end
      default: begin
        txd_n   = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  assign input_axi_tready = tready_q;
  assign txd              = txd_q;
  assign busy             = (state != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: reset, framing, parity, stop bits,
// back-to-back streaming, prescale corner cases and mid-frame reset.
module tb_uart_tx;

  logic        clk;
  logic        rst_n;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic        txd;
  logic        busy;
  logic [15:0] prescale;
  logic [1:0]  parity_mode;
  logic        stop_bits;

  int vectors;
  int miscompares;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .input_axi_tdata (tdata),
    .input_axi_tvalid(tvalid),
    .input_axi_tready(tready),
    .txd             (txd),
    .busy            (busy),
    .prescale        (prescale),
    .parity_mode     (parity_mode),
    .stop_bits       (stop_bits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Waits for tready, then presents one word for exactly one handshake edge.
  task automatic send_word(input logic [7:0] d);
    int waited;
    waited = 0;
    @(negedge clk);
    while (tready !== 1'b1 && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    if (tready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL send_word tready timeout: got %b want 1", tready);
    end
    tdata  = d;
    tvalid = 1'b1;
    @(posedge clk);
    #1;
    tvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors += 3;
    if (txd !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset txd: got %b want 1", txd);
    end
    if (tready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset tready: got %b want 0", tready);
    end
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset busy: got %b want 0", busy);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (tready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL release tready before edge: got %b want 0", tready);
    end
    @(negedge clk);
    vectors++;
    if (tready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL release tready after edge: got %b want 1", tready);
    end
  endtask

  task automatic test_basic_frame();
    logic [11:0] exp;
    exp = {1'b1, 8'h55, 1'b0};
    prescale = 16'd1; parity_mode = 2'd0; stop_bits = 1'b0;
    send_word(8'h55);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      vectors++;
      if (txd !== exp[i/8]) begin
        miscompares++;
        $display("[TB] FAIL basic txd cycle %0d: got %b want %b", i, txd, exp[i/8]);
      end
      if (i == 0) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL basic busy: got %b want 1", busy);
        end
      end
    end
    vectors++;
    if (tready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic tready at 79: got %b want 0", tready);
    end
    @(negedge clk);
    vectors += 2;
    if (tready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL basic tready at 80: got %b want 1", tready);
    end
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic busy at end: got %b want 0", busy);
    end
  endtask

  task automatic test_parity_odd();
    logic [11:0] exp;
    exp = {1'b1, 1'b1, 8'h03, 1'b0};
    prescale = 16'd2; parity_mode = 2'd2; stop_bits = 1'b0;
    send_word(8'h03);
    for (int i = 0; i < 11 * 16; i++) begin
      @(negedge clk);
      vectors++;
      if (txd !== exp[i/16]) begin
        miscompares++;
        $display("[TB] FAIL parity_odd txd cycle %0d: got %b want %b", i, txd, exp[i/16]);
      end
    end
    @(negedge clk);
    vectors++;
    if (tready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL parity_odd tready at end: got %b want 1", tready);
    end
  endtask

  task automatic test_parity_even_two_stop();
    logic [11:0] exp;
    exp = {2'b11, 1'b1, 8'h07, 1'b0};
    prescale = 16'd2; parity_mode = 2'd1; stop_bits = 1'b1;
    send_word(8'h07);
    for (int i = 0; i < 12 * 16; i++) begin
      @(negedge clk);
      vectors++;
      if (txd !== exp[i/16]) begin
        miscompares++;
        $display("[TB] FAIL even_2stop txd cycle %0d: got %b want %b", i, txd, exp[i/16]);
      end
    end
    vectors++;
    if (tready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL even_2stop tready in stop: got %b want 0", tready);
    end
    @(negedge clk);
    vectors++;
    if (tready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL even_2stop tready at end: got %b want 1", tready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    logic       samples [400];
    int         hs [3];
    int         k;
    logic [7:0] rx;
    words = '{8'hA5, 8'h0F, 8'hFF};
    prescale = 16'd1; parity_mode = 2'd0; stop_bits = 1'b0;
    k = 0;
    @(negedge clk);
    tdata  = words[0];
    tvalid = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      samples[c] = txd;
      if (tvalid && tready && k < 3) begin
        hs[k] = c;
        k++;
        @(posedge clk);
        #1;
        if (k < 3) tdata = words[k];
        else tvalid = 1'b0;
      end
    end
    tvalid = 1'b0;
    vectors++;
    if (k != 3) begin
      miscompares++;
      $display("[TB] FAIL b2b handshakes: got %0d want 3", k);
    end else begin
      for (int f = 0; f < 3; f++) begin
        if (f > 0) begin
          vectors++;
          if (hs[f] - hs[f-1] != 81) begin
            miscompares++;
            $display("[TB] FAIL b2b spacing %0d: got %0d want 81", f, hs[f] - hs[f-1]);
          end
        end
        for (int j = 0; j < 8; j++) rx[j] = samples[hs[f] + 1 + (1 + j) * 8 + 4];
        vectors += 3;
        if (samples[hs[f] + 1 + 4] !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL b2b start bit %0d: got %b want 0", f, samples[hs[f] + 5]);
        end
        if (rx !== words[f]) begin
          miscompares++;
          $display("[TB] FAIL b2b rx word %0d: got %h want %h", f, rx, words[f]);
        end
        if (samples[hs[f] + 1 + 72 + 4] !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL b2b stop bit %0d: got %b want 1", f, samples[hs[f] + 77]);
        end
      end
    end
  endtask

  task automatic test_prescale_zero();
    logic [11:0] exp;
    exp = {1'b1, 8'h3C, 1'b0};
    prescale = 16'd0; parity_mode = 2'd0; stop_bits = 1'b0;
    send_word(8'h3C);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      vectors++;
      if (txd !== exp[i/8]) begin
        miscompares++;
        $display("[TB] FAIL prescale0 txd cycle %0d: got %b want %b", i, txd, exp[i/8]);
      end
    end
    @(negedge clk);
    vectors++;
    if (tready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL prescale0 tready at end: got %b want 1", tready);
    end
  endtask

  task automatic test_prescale_change();
    logic [11:0] exp;
    exp = {1'b1, 8'h96, 1'b0};
    prescale = 16'd1; parity_mode = 2'd0; stop_bits = 1'b0;
    send_word(8'h96);
    prescale = 16'd5; parity_mode = 2'd2; stop_bits = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      vectors++;
      if (txd !== exp[i/8]) begin
        miscompares++;
        $display("[TB] FAIL cfg_change txd cycle %0d: got %b want %b", i, txd, exp[i/8]);
      end
    end
    @(negedge clk);
    vectors++;
    if (tready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL cfg_change tready at end: got %b want 1", tready);
    end
    prescale = 16'd1; parity_mode = 2'd0; stop_bits = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [11:0] exp;
    logic        idle_ok;
    prescale = 16'd1; parity_mode = 2'd0; stop_bits = 1'b0;
    send_word(8'hFF);
    repeat (12) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midreset busy before: got %b want 1", busy);
    end
    rst_n = 1'b0;
    #1;
    vectors += 3;
    if (txd !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midreset txd: got %b want 1", txd);
    end
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset busy: got %b want 0", busy);
    end
    if (tready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset tready: got %b want 0", tready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) idle_ok = 1'b0;
    end
    vectors++;
    if (idle_ok !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL midreset resend: got activity want idle line");
    end
    exp = {1'b1, 8'h81, 1'b0};
    send_word(8'h81);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      vectors++;
      if (txd !== exp[i/8]) begin
        miscompares++;
        $display("[TB] FAIL midreset next txd cycle %0d: got %b want %b", i, txd, exp[i/8]);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    tdata       = 8'h00;
    tvalid      = 1'b0;
    prescale    = 16'd1;
    parity_mode = 2'd0;
    stop_bits   = 1'b0;
    test_reset();
    test_basic_frame();
    test_parity_odd();
    test_parity_even_two_stop();
    test_back_to_back();
    test_prescale_zero();
    test_prescale_change();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
